// File: rtl/craft_round_key_gen.sv
// CRAFT round-key sequencer: issues one (tweakey, rc_a, rc_b) bundle per valid/ready handshake.
// Optional reverse (decrypt) issue order is enabled by defining CRAFT_RKG_DECRYPT_EN.
module craft_round_key_gen #(
    parameter int NUM_ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
`ifdef CRAFT_RKG_DECRYPT_EN
    input  logic         dir,
`endif
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [63:0]  rk_tk,
    output logic [3:0]   rk_rc_a,
    output logic [2:0]   rk_rc_b,
    output logic [4:0]   rk_round,
    output logic         rk_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [4:0]  LAST_ROUND = 5'(NUM_ROUNDS - 1);
    // Nibble i of Q(T) is nibble Q_PERM[i] of T; nibble 0 is the most significant.
    localparam logic [63:0] Q_PERM     = 64'hCAF5_E892_B374_601D;

    function automatic logic [63:0] q_perm(input logic [63:0] t);
        logic [63:0] q;
        logic [3:0]  src;
        q = 64'h0;
        for (int i = 0; i < 16; i++) begin
            src = Q_PERM[63-4*i -: 4];
            q[63-4*i -: 4] = t[63-4*int'(src) -: 4];
        end
        return q;
    endfunction

    function automatic logic [63:0] key_schedule(input logic [127:0] k, input logic [63:0] t,
                                                 input logic [1:0] sel);
        logic [63:0] half;
        logic [63:0] tw;
        half = sel[0] ? k[63:0] : k[127:64];
        tw   = sel[1] ? q_perm(t) : t;
        return half ^ tw;
    endfunction

    function automatic logic [3:0] lfsr_a_fwd(input logic [3:0] a);
        return {a[2:0], a[3] ^ a[2]};
    endfunction

    function automatic logic [2:0] lfsr_b_fwd(input logic [2:0] b);
        return {b[1:0], b[2] ^ b[1]};
    endfunction

    function automatic logic [3:0] lfsr_a_inv(input logic [3:0] a);
        return {a[0] ^ a[3], a[3:1]};
    endfunction

    function automatic logic [2:0] lfsr_b_inv(input logic [2:0] b);
        return {b[0] ^ b[2], b[2:1]};
    endfunction

    function automatic logic [3:0] lfsr_a_steps(input int n);
        logic [3:0] a;
        a = 4'b0001;
        for (int i = 0; i < n; i++) a = lfsr_a_fwd(a);
        return a;
    endfunction

    function automatic logic [2:0] lfsr_b_steps(input int n);
        logic [2:0] b;
        b = 3'b001;
        for (int i = 0; i < n; i++) b = lfsr_b_fwd(b);
        return b;
    endfunction

    localparam logic [3:0] A_REV_INIT = lfsr_a_steps(NUM_ROUNDS - 1);
    localparam logic [2:0] B_REV_INIT = lfsr_b_steps(NUM_ROUNDS - 1);

    state_t         state_r, state_s;
    logic [127:0]   key_r, key_s;
    logic [63:0]    tweak_r, tweak_s;
    logic           rev_r, rev_s;
    logic           start_rev_s;
    logic           valid_s, last_s, busy_s, done_s;
    logic [63:0]    tk_s;
    logic [3:0]     a_s;
    logic [2:0]     b_s;
    logic [4:0]     round_s;

`ifdef CRAFT_RKG_DECRYPT_EN
    assign start_rev_s = dir;
`else
    assign start_rev_s = 1'b0;
`endif

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        tweak_s = tweak_r;
        rev_s   = rev_r;
        valid_s = rk_valid;
        tk_s    = rk_tk;
        a_s     = rk_rc_a;
        b_s     = rk_rc_b;
        round_s = rk_round;
        last_s  = rk_last;
        busy_s  = busy;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    key_s   = key;
                    tweak_s = tweak;
                    rev_s   = start_rev_s;
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                    last_s  = 1'b0;
                    if (start_rev_s) begin
                        round_s = LAST_ROUND;
                        a_s     = A_REV_INIT;
                        b_s     = B_REV_INIT;
                    end else begin
                        round_s = 5'd0;
                        a_s     = 4'b0001;
                        b_s     = 3'b001;
                    end
                    tk_s = key_schedule(key, tweak, round_s[1:0]);
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (rk_valid && rk_ready) begin
                    if (rk_last) begin
                        state_s = IDLE;
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
                        last_s  = 1'b0;
                        done_s  = 1'b1;
                    end else if (rev_r) begin
                        round_s = rk_round - 5'd1;
                        a_s     = lfsr_a_inv(rk_rc_a);
                        b_s     = lfsr_b_inv(rk_rc_b);
                        last_s  = (round_s == 5'd0);
                        tk_s    = key_schedule(key_r, tweak_r, round_s[1:0]);
                    end else begin
                        round_s = rk_round + 5'd1;
                        a_s     = lfsr_a_fwd(rk_rc_a);
                        b_s     = lfsr_b_fwd(rk_rc_b);
                        last_s  = (round_s == LAST_ROUND);
                        tk_s    = key_schedule(key_r, tweak_r, round_s[1:0]);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                busy_s  = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // State, latched operands and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            key_r    <= 128'h0;
            tweak_r  <= 64'h0;
            rev_r    <= 1'b0;
            rk_valid <= 1'b0;
            rk_tk    <= 64'h0;
            rk_rc_a  <= 4'h0;
            rk_rc_b  <= 3'h0;
            rk_round <= 5'd0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            key_r    <= key_s;
            tweak_r  <= tweak_s;
            rev_r    <= rev_s;
            rk_valid <= valid_s;
            rk_tk    <= tk_s;
            rk_rc_a  <= a_s;
            rk_rc_b  <= b_s;
            rk_round <= round_s;
            rk_last  <= last_s;
            busy     <= busy_s;
            done     <= done_s;
        end
    end

endmodule
